// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one multi-cycle memory among NUM_PORTS requesters.
// Optional per-request timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arb #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            valid_i,
    input  logic [NUM_PORTS-1:0]            write_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   byte_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     wdata_i,
    output logic [NUM_PORTS-1:0]            busy_o,
    output logic [DATA_W-1:0]               rdata_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic                            mem_req,
    output logic                            mem_write,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W/8-1:0]             mem_byte,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_ready
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (NUM_PORTS < 2 || (DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_param_chk
        $error("mem_arb: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } attr_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  grant_q, grant_d;
    logic              mem_req_q, mem_req_d;
    attr_t             attr_q, attr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PTR_W-1:0]  sel;
    logic [NUM_PORTS-1:0] resp_mask;

    // First requesting port at or after the priority pointer, wrapping.
    function automatic logic [PTR_W-1:0] pick_port(
        input logic [NUM_PORTS-1:0] req,
        input logic [PTR_W-1:0]     start
    );
        logic [PTR_W-1:0] res;
        logic             found;
        int unsigned      j;
        res   = start;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            j = 32'(start) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!found && req[j]) begin
                res   = PTR_W'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign sel = pick_port(valid_i, ptr_q);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] err_q, err_d;

    function automatic logic [DATA_W-1:0] dead_fill();
        logic [31:0]       pat;
        logic [DATA_W-1:0] r;
        pat = 32'hDEADBEEF;
        r   = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            r[b*8 +: 8] = pat[(b%4)*8 +: 8];
        end
        return r;
    endfunction
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        mem_req_d = mem_req_q;
        attr_d    = attr_q;
        rdata_d   = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|valid_i) begin
                    grant_d      = sel;
                    mem_req_d    = 1'b1;
                    attr_d.write = write_i[sel];
                    attr_d.addr  = addr_i[32'(sel)*ADDR_W +: ADDR_W];
                    attr_d.be    = byte_i[32'(sel)*BE_W +: BE_W];
                    attr_d.wdata = wdata_i[32'(sel)*DATA_W +: DATA_W];
                    state_d      = REQ;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (!attr_q.write) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Expired: abort with a recognisable poison value.
                    mem_req_d      = 1'b0;
                    rdata_d        = dead_fill();
                    err_d[grant_q] = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                ptr_d   = (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            mem_req_q <= 1'b0;
            attr_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            mem_req_q <= mem_req_d;
            attr_q    <= attr_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    // Stall every requester except the granted port during its done cycle.
    always_comb begin
        resp_mask = '0;
        if (state_q == RESP) begin
            resp_mask[grant_q] = 1'b1;
        end
        busy_o = valid_i & ~resp_mask;
    end

    assign rdata_o   = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_write = attr_q.write;
    assign mem_addr  = attr_q.addr;
    assign mem_byte  = attr_q.be;
    assign mem_wdata = attr_q.wdata;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a latency-programmable memory model.
module tb_mem_arb;

    localparam int unsigned NP  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     valid_i, write_i, busy_o, err_o;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*BW-1:0]  byte_i;
    logic [NP*DW-1:0]  wdata_i;
    logic [DW-1:0]     rdata_o, mem_wdata, mem_rdata;
    logic              mem_req, mem_write, mem_ready;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     mem_byte;

    mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .write_i(write_i), .addr_i(addr_i),
        .byte_i(byte_i), .wdata_i(wdata_i), .busy_o(busy_o), .rdata_o(rdata_o),
        .err_o(err_o), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          mlat;
        int          lat;
        logic [31:0] mdata;
        logic [31:0] exp_rd;
        bit          err;
        bit          drop;
        bit          b2b;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          req_len = 0;
    int          cur_lat = 0;
    int          last_resp_cyc = 0;
    int          ptr_m = 0;
    logic [31:0] cur_data = '0;
    logic [31:0] rd_model = '0;
    logic        mem_req_prev = 1'b0;
    bit          mem_manual = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One cycle: retire completions, check handshakes, then drive the memory model.
    task automatic step();
        exp_t          e;
        logic [NP-1:0] resp_mask;
        int            done_port;
        @(negedge clk);
        cyc++;
        resp_mask = '0;
        done_port = -1;
        if (mem_req_prev && !mem_req && q.size() > 0) begin
            e = q.pop_front();
            done_port = e.port;
            if (!e.drop) resp_mask[e.port] = 1'b1;
            check("req_len", 64'(req_len), 64'(e.lat));
            if (!e.drop) check("rdata", 64'(rdata_o), 64'(e.exp_rd));
            check("err", 64'(err_o), e.err ? (64'd1 << e.port) : 64'd0);
            ptr_m = (e.port + 1) % NP;
            last_resp_cyc = cyc;
        end
        check("busy", 64'(busy_o), 64'(valid_i & ~resp_mask));
        if (mem_req && !mem_req_prev) begin
            req_len = 0;
            if (q.size() == 0) begin
                check("unexp_req", 64'(mem_req), 64'd0);
            end else begin
                e = q[0];
                check("m_write", 64'(mem_write), 64'(e.wr));
                check("m_addr", 64'(mem_addr), 64'(e.addr));
                check("m_byte", 64'(mem_byte), 64'(e.be));
                check("m_wdata", 64'(mem_wdata), 64'(e.wd));
                if (e.b2b) check("bubble", 64'(cyc - last_resp_cyc), 64'd2);
                cur_lat  = e.mlat;
                cur_data = e.mdata;
            end
        end
        if (mem_req) req_len++;
        if (!mem_manual) begin
            mem_ready = mem_req && (cur_lat != 0) && (req_len == cur_lat);
            mem_rdata = mem_ready ? cur_data : (32'hBAD00000 | 32'(cyc));
        end
        mem_req_prev = mem_req;
        if (done_port >= 0) valid_i[done_port] = 1'b0;
    endtask

    task automatic drive(input int p, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        valid_i[p]          = 1'b1;
        write_i[p]          = wr;
        addr_i[p*AW +: AW]  = a;
        byte_i[p*BW +: BW]  = be;
        wdata_i[p*DW +: DW] = wd;
    endtask

    // mlat = 0 models a memory that never answers.
    task automatic push(input int p, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int mlat, input logic [31:0] md,
                        input bit drop, input bit b2b);
        exp_t e;
        e.port = p; e.wr = wr; e.addr = a; e.be = be; e.wd = wd;
        e.mlat = mlat; e.mdata = md; e.drop = drop; e.b2b = b2b;
        e.lat  = (mlat == 0) ? TMO : mlat;
        e.err  = (mlat == 0);
        if (mlat == 0)  e.exp_rd = 32'hDEADBEEF;
        else if (wr)    e.exp_rd = rd_model;
        else            e.exp_rd = md;
        rd_model = e.exp_rd;
        q.push_back(e);
    endtask

    task automatic req(input int p, input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int mlat, input logic [31:0] md, input bit drop);
        drive(p, wr, a, be, wd);
        push(p, wr, a, be, wd, mlat, md, drop, 1'b0);
    endtask

    // Both ports request in the same cycle; order follows the modelled pointer.
    task automatic pair(input int mlat, input logic [31:0] d0, input logic [31:0] d1);
        int f, s;
        f = ptr_m;
        s = (ptr_m + 1) % NP;
        drive(0, 1'b0, 32'h1000, 4'hF, 32'h0);
        drive(1, 1'b0, 32'h2000, 4'hF, 32'h0);
        push(f, 1'b0, (f == 0) ? 32'h1000 : 32'h2000, 4'hF, 32'h0, mlat, (f == 0) ? d0 : d1, 1'b0, 1'b0);
        push(s, 1'b0, (s == 0) ? 32'h1000 : 32'h2000, 4'hF, 32'h0, mlat, (s == 0) ? d0 : d1, 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        if (q.size() != 0) begin
            q.delete();
            valid_i = '0;
        end
        step();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!mem_req && n < budget) begin
            step();
            n++;
        end
        check("req_seen", 64'(mem_req), 64'd1);
    endtask

    initial begin
        rst = 1'b0;
        valid_i = '0; write_i = '0; addr_i = '0; byte_i = '0; wdata_i = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) step();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_byte", 64'(mem_byte), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b1;
        step();

        pair(2, 32'hA0A0A0A0, 32'hB1B1B1B1);
        wait_done(40);
        pair(1, 32'hC2C2C2C2, 32'hD3D3D3D3);
        wait_done(40);

        req(0, 1'b0, 32'h100, 4'hF, 32'h0, 3, 32'h12345678, 1'b0);
        wait_done(30);
        pair(2, 32'h0F0F0F0F, 32'hF0F0F0F0);
        wait_done(40);

        req(1, 1'b1, 32'h200, 4'b0011, 32'hAABBCCDD, 2, 32'h99999999, 1'b0);
        wait_done(30);
        req(1, 1'b0, 32'h204, 4'hF, 32'h0, 1, 32'h13579BDF, 1'b0);
        wait_done(30);

        mem_manual = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
        step();
        mem_ready = 1'b0;
        step(); step();
        check("spur_rdata", 64'(rdata_o), 64'(rd_model));
        check("spur_req", 64'(mem_req), 64'd0);
        mem_manual = 1'b0;

        req(1, 1'b0, 32'h300, 4'hF, 32'h0, 4, 32'h55AA55AA, 1'b1);
        wait_req(10);
        step();
        valid_i[1] = 1'b0;
        wait_done(30);
        check("drop_idle", 64'(mem_req), 64'd0);

        req(0, 1'b0, 32'h400, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        wait_req(10);
        step(); step();
        rst = 1'b0;
        #1;
        check("rstmid_req", 64'(mem_req), 64'd0);
        check("rstmid_busy", 64'(busy_o), 64'd1);
        q.delete();
        mem_req_prev = 1'b0;
        ptr_m = 0;
        rd_model = '0;
        mem_manual = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ready = 1'b0;
        step();
        valid_i = '0;
        step();
        rst = 1'b1;
        step(); step();
        check("rstmid_rdata", 64'(rdata_o), 64'd0);
        check("rstmid_idle", 64'(mem_req), 64'd0);
        mem_manual = 1'b0;

        req(1, 1'b0, 32'h500, 4'hF, 32'h0, 2, 32'h2468ACE0, 1'b0);
        wait_done(30);

`ifdef MEM_ARB_TIMEOUT_EN
        req(0, 1'b0, 32'h600, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        wait_done(60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
